mem_access_unit: RTL

- Sits between the pipeline MEM stage and the word-addressed data RAM (sync write, async read, no byte enables).
- Turns RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word RAM accesses.
- Loads: byte-lane extraction with sign or zero extension.
- Sub-word stores: 2-cycle read-modify-write with a pipeline stall. Misaligned accesses are detected and suppressed.

---
 rtl/mem_access_pkg.sv | 24 ++
 rtl/lane_align.sv | 42 ++++
 rtl/mem_access_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared RV32I load/store encodings and FSM state type for the memory access unit.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, RMW_WR} mau_state_t;

  // Undefined funct3 codes fall into the default arm and count as misaligned.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = lo[0];
      F3_W:        mis = (lo != 2'b00);
      default:     mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte/half lane handling: load extraction with extension and store lane merge.
module lane_align
  import mem_access_pkg::*;
#(
  parameter int size = 32
) (
  input  logic [size-1:0] word,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  input  logic [size-1:0] store_data,
  output logic [size-1:0] load_val,
  output logic [size-1:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{addr_lo, 3'b000} +: 8];
  assign half_sel = word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    load_val = '0;
    case (funct3)
      F3_B:    load_val = {{(size-8){byte_sel[7]}}, byte_sel};
      F3_BU:   load_val = {{(size-8){1'b0}}, byte_sel};
      F3_H:    load_val = {{(size-16){half_sel[15]}}, half_sel};
      F3_HU:   load_val = {{(size-16){1'b0}}, half_sel};
      F3_W:    load_val = word;
      default: load_val = '0;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3)
      F3_B, F3_BU: merged[{addr_lo, 3'b000} +: 8]     = store_data[7:0];
      F3_H, F3_HU: merged[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
      default:     merged = store_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit for a word-addressed RAM; sub-word stores are done
// as a stalled two-cycle read-modify-write.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int mem_depth = 1024,
  parameter int size      = 32,
  parameter int ADDR_W    = $clog2(mem_depth)
) (
  input  logic              CLK,
  input  logic              RSTa,
  input  logic              MemRead_mem,
  input  logic              MemWrite_mem,
  input  logic [2:0]        funct3_mem,
  input  logic [31:0]       address_mem,
  input  logic [size-1:0]   store_data_mem,
  output logic [size-1:0]   load_data,
  output logic              stall,
  output logic              misaligned,
  output logic              misaligned_sticky,
  output logic [ADDR_W-1:0] ram_address,
  output logic [size-1:0]   ram_write_data,
  output logic              ram_memwrite,
  input  logic [size-1:0]   ram_read_data
);

  mau_state_t        state_q, state_d;
  logic [size-1:0]   merged_q, merged_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              sticky_q, sticky_d;

  logic [ADDR_W-1:0] live_idx;
  logic [size-1:0]   lane_load, lane_merged;
  logic              req, both, addr_mis, wr_en;
  logic              unused_addr_hi;

  assign live_idx       = address_mem[ADDR_W+1:2];
  assign unused_addr_hi = ^address_mem[31:ADDR_W+2];
  assign req            = MemRead_mem | MemWrite_mem;
  assign both           = MemRead_mem & MemWrite_mem;
  assign addr_mis       = f3_misaligned(funct3_mem, address_mem[1:0]);

  lane_align #(.size(size)) u_lane_align (
    .word       (ram_read_data),
    .addr_lo    (address_mem[1:0]),
    .funct3     (funct3_mem),
    .store_data (store_data_mem),
    .load_val   (lane_load),
    .merged     (lane_merged)
  );

  always_comb begin
    state_d        = state_q;
    merged_d       = merged_q;
    idx_d          = idx_q;
    load_data      = '0;
    stall          = 1'b0;
    misaligned     = 1'b0;
    wr_en          = 1'b0;
    ram_address    = live_idx;
    ram_write_data = store_data_mem;
    case (state_q)
      IDLE: begin
        // Conflicting read+write is reported like a misaligned access: nothing issued.
        if (both || (req && addr_mis)) begin
          misaligned = 1'b1;
        end else if (MemWrite_mem) begin
          if (funct3_mem == F3_W) begin
            wr_en = 1'b1;
          end else begin
            stall    = 1'b1;
            merged_d = lane_merged;
            idx_d    = live_idx;
            state_d  = RMW_WR;
          end
        end else if (MemRead_mem) begin
          load_data = lane_load;
        end
      end
      RMW_WR: begin
        ram_address    = idx_q;
        ram_write_data = merged_q;
        wr_en          = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    sticky_d = sticky_q | misaligned;
  end

  assign ram_memwrite      = wr_en & ~RSTa;
  assign misaligned_sticky = sticky_q;

  always_ff @(posedge CLK) begin
    if (RSTa) begin
      state_q  <= IDLE;
      merged_q <= '0;
      idx_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      merged_q <= merged_d;
      idx_q    <= idx_d;
      sticky_q <= sticky_d;
    end
  end

endmodule
